// File: rtl/fix_fft_pkg.sv
// Shared definitions for the fixed-point FFT datapath: scheduler FSM states and the
// radix-2 DIT in-place butterfly address functions.
package fix_fft_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } bf_state_e;

  // Low operand index of pair k in stage s; the input is taken in bit-reversed order.
  function automatic int unsigned bf_addr_a(input int unsigned s, input int unsigned k);
    return ((k >> s) << (s + 32'd1)) + (k & ((32'd1 << s) - 32'd1));
  endfunction

  function automatic int unsigned bf_addr_b(input int unsigned s, input int unsigned k);
    return bf_addr_a(s, k) + (32'd1 << s);
  endfunction

  function automatic int unsigned bf_tw(input int unsigned log2n, input int unsigned s,
                                        input int unsigned k);
    return (k & ((32'd1 << s) - 32'd1)) << (log2n - 32'd1 - s);
  endfunction

endpackage

// File: rtl/fix_addr_fifo.sv
// Small synchronous FIFO holding writeback address pairs for butterflies in flight.
// The head is visible combinationally on rdata.
module fix_addr_fifo #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CntW'(Depth));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= ptr_inc(wptr_q);
      if (do_pop)  rptr_q <= ptr_inc(rptr_q);
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Storage needs no reset: only entries behind a valid count are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/fix_bf_sched.sv
// Butterfly scheduler for an in-place radix-2 DIT FFT: issues operand reads stage by
// stage, bounds butterflies in flight, and writes results back in issue order.
module fix_bf_sched
  import fix_fft_pkg::*;
#(
  parameter int unsigned LOG2N   = 8,
  parameter int unsigned MAX_OUT = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(LOG2N)-1:0] stage,
  output logic                     mem_rd_en,
  output logic [LOG2N-1:0]         rd_addr_a,
  output logic [LOG2N-1:0]         rd_addr_b,
  output logic [LOG2N-2:0]         tw_addr,
  output logic                     en,
  input  logic                     vld_out,
  input  logic                     overflow,
  output logic                     mem_wr_en,
  output logic [LOG2N-1:0]         wr_addr_a,
  output logic [LOG2N-1:0]         wr_addr_b,
  output logic                     ovf_sticky,
  output logic                     err
);

  localparam int unsigned AW = LOG2N;
  localparam int unsigned KW = LOG2N - 1;
  localparam int unsigned SW = $clog2(LOG2N);
  localparam int unsigned CW = $clog2(MAX_OUT + 1);

  bf_state_e       state_q, state_d;
  logic [SW-1:0]   stage_q, stage_d;
  logic [KW-1:0]   k_q, k_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            en_q;
  logic            ovf_q, ovf_d;
  logic            err_q, err_d;

  logic            issue, pop, start_ok, last_k, last_stage;
  logic            fifo_full, fifo_empty;
  logic [2*AW-1:0] fifo_head;

  assign start_ok   = start && (state_q == StIdle);
  assign issue      = (state_q == StIssue) && (cnt_q < CW'(MAX_OUT));
  assign pop        = vld_out && !fifo_empty;
  assign last_k     = (k_q == {KW{1'b1}});
  assign last_stage = (stage_q == SW'(LOG2N - 1));

  // Addresses are forced to zero when idle so every output reads 0 under reset.
  assign mem_rd_en = issue;
  assign rd_addr_a = issue ? AW'(bf_addr_a(32'(stage_q), 32'(k_q))) : '0;
  assign rd_addr_b = issue ? AW'(bf_addr_b(32'(stage_q), 32'(k_q))) : '0;
  assign tw_addr   = issue ? KW'(bf_tw(LOG2N, 32'(stage_q), 32'(k_q))) : '0;

  assign mem_wr_en = pop;
  assign wr_addr_a = pop ? fifo_head[2*AW-1:AW] : '0;
  assign wr_addr_b = pop ? fifo_head[AW-1:0] : '0;

  assign busy       = (state_q == StIssue) || (state_q == StDrain);
  assign done       = (state_q == StDone);
  assign stage      = stage_q;
  assign en         = en_q;
  assign ovf_sticky = ovf_q;
  assign err        = err_q;

  fix_addr_fifo #(
    .Width(2 * AW),
    .Depth(MAX_OUT)
  ) u_addr_fifo (
    .clk  (clk),
    .rstn (rstn),
    .push (issue),
    .pop  (pop),
    .wdata({rd_addr_a, rd_addr_b}),
    .rdata(fifo_head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    k_d     = k_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StIssue;
          stage_d = '0;
          k_d     = '0;
        end
      end
      StIssue: begin
        if (issue) begin
          k_d = k_q + 1'b1;
          if (last_k) begin
            state_d = StDrain;
            k_d     = '0;
          end
        end
      end
      // Stage barrier: the next stage only starts once every writeback has landed.
      StDrain: begin
        if (cnt_q == '0) begin
          if (last_stage) begin
            state_d = StDone;
          end else begin
            state_d = StIssue;
            stage_d = stage_q + 1'b1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (issue && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !issue) cnt_d = cnt_q - 1'b1;

    ovf_d = start_ok ? 1'b0 : ovf_q;
    err_d = start_ok ? 1'b0 : err_q;
    if (vld_out && overflow)   ovf_d = 1'b1;
    if (vld_out && fifo_empty) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      stage_q <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      en_q    <= issue;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_fix_bf_sched.sv
// Bench for fix_bf_sched with N=8: instance 0 has MAX_OUT=8 and a latency-3 butterfly,
// instance 1 has MAX_OUT=2 and a latency-5 butterfly; a negedge monitor drains a scoreboard.
module tb_fix_bf_sched;

  localparam int unsigned L = 3;

  logic       clk = 1'b0;
  logic       rstn;
  logic       pipe_clr;
  logic       start     [2];
  logic       busy      [2];
  logic       done      [2];
  logic [1:0] stage     [2];
  logic       mem_rd_en [2];
  logic [2:0] rd_a      [2];
  logic [2:0] rd_b      [2];
  logic [1:0] tw        [2];
  logic       en        [2];
  logic       vld       [2];
  logic       ovf_in    [2];
  logic       mem_wr_en [2];
  logic [2:0] wr_a      [2];
  logic [2:0] wr_b      [2];
  logic       ovf_st    [2];
  logic       err       [2];
  logic [4:0] pipe      [2];
  logic       spur      [2];
  logic       ovf_arm   [2];
  logic       vcnt_clr  [2];
  int         vcnt      [2];

  // Hand-computed read vectors for N=8, encoded a*100 + b*10 + tw; writes are a*10 + b.
  int rd_tab [12] = '{10, 230, 450, 670,
                      20, 132, 460, 572,
                      40, 151, 262, 373};
  int wr_tab [12] = '{1, 23, 45, 67,
                      2, 13, 46, 57,
                      4, 15, 26, 37};

  int exp_rd [2][$];
  int exp_wr [2][$];
  bit exp_ovf [2];
  int rd_cnt [2], wr_cnt [2], peak [2], last_wr [2], done_cnt [2];
  int cyc;
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    fix_bf_sched #(
      .LOG2N  (L),
      .MAX_OUT(g == 0 ? 8 : 2)
    ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .start     (start[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .stage     (stage[g]),
      .mem_rd_en (mem_rd_en[g]),
      .rd_addr_a (rd_a[g]),
      .rd_addr_b (rd_b[g]),
      .tw_addr   (tw[g]),
      .en        (en[g]),
      .vld_out   (vld[g]),
      .overflow  (ovf_in[g]),
      .mem_wr_en (mem_wr_en[g]),
      .wr_addr_a (wr_a[g]),
      .wr_addr_b (wr_b[g]),
      .ovf_sticky(ovf_st[g]),
      .err       (err[g])
    );

    // Butterfly model: a pure delay line on en, deliberately not reset by rstn.
    assign vld[g]    = (g == 0 ? pipe[g][2] : pipe[g][4]) | spur[g];
    assign ovf_in[g] = vld[g] && ovf_arm[g] && (vcnt[g] == 6);

    always @(posedge clk) begin
      if (pipe_clr) pipe[g] <= '0;
      else          pipe[g] <= {pipe[g][3:0], en[g]};
      if (vcnt_clr[g])  vcnt[g] <= 0;
      else if (vld[g])  vcnt[g] <= vcnt[g] + 1;
    end
  end

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int outs(input int g);
    return int'({busy[g], done[g], stage[g], mem_rd_en[g], rd_a[g], rd_b[g], tw[g], en[g],
                 mem_wr_en[g], wr_a[g], wr_b[g], ovf_st[g], err[g]});
  endfunction

  // Monitor: pops the scoreboard on every read/write the DUT presents.
  always @(negedge clk) begin
    cyc++;
    for (int g = 0; g < 2; g++) begin
      if (start[g] && !busy[g] && !done[g]) begin
        rd_cnt[g] = 0;
        wr_cnt[g] = 0;
        peak[g]   = 0;
        last_wr[g] = 0;
      end
      if (mem_wr_en[g]) begin
        if (exp_wr[g].size() == 0) begin
          chk(1'b0, "unexpected_write", int'(wr_a[g]) * 10 + int'(wr_b[g]), -1);
        end else begin
          int e;
          e = exp_wr[g].pop_front();
          chk(int'(wr_a[g]) * 10 + int'(wr_b[g]) == e, "write_addr",
              int'(wr_a[g]) * 10 + int'(wr_b[g]), e);
        end
        wr_cnt[g]++;
        last_wr[g] = cyc;
      end
      if (mem_rd_en[g]) begin
        int act;
        act = int'(rd_a[g]) * 100 + int'(rd_b[g]) * 10 + int'(tw[g]);
        if (exp_rd[g].size() == 0) begin
          chk(1'b0, "unexpected_read", act, -1);
        end else begin
          int e;
          e = exp_rd[g].pop_front();
          chk(act == e, "read_addr_tw", act, e);
        end
        if (rd_cnt[g] == 4 || rd_cnt[g] == 8)
          chk(wr_cnt[g] == rd_cnt[g] && cyc > last_wr[g], "stage_barrier", wr_cnt[g], rd_cnt[g]);
        rd_cnt[g]++;
      end
      if (rd_cnt[g] - wr_cnt[g] > peak[g]) peak[g] = rd_cnt[g] - wr_cnt[g];
      if (done[g]) begin
        done_cnt[g]++;
        chk(wr_cnt[g] == 12, "writes_at_done", wr_cnt[g], 12);
        chk(ovf_st[g] == exp_ovf[g], "ovf_at_done", int'(ovf_st[g]), int'(exp_ovf[g]));
        chk(err[g] == 1'b0, "err_at_done", int'(err[g]), 0);
      end
    end
  end

  task automatic push_run(input int g);
    for (int i = 0; i < 12; i++) begin
      exp_rd[g].push_back(rd_tab[i]);
      exp_wr[g].push_back(wr_tab[i]);
    end
  endtask

  task automatic do_start(input int g);
    @(posedge clk);
    #1 start[g] = 1'b1;
    vcnt_clr[g] = 1'b1;
    @(posedge clk);
    #1 start[g] = 1'b0;
    vcnt_clr[g] = 1'b0;
    chk(busy[g] == 1'b1, "busy_after_start", int'(busy[g]), 1);
    chk({ovf_st[g], err[g]} == 2'b00, "flags_cleared_by_start", int'({ovf_st[g], err[g]}), 0);
  endtask

  task automatic wait_done(input int g);
    int d0;
    bit seen;
    d0   = done_cnt[g];
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(posedge clk);
      if (done_cnt[g] != d0) seen = 1'b1;
    end
    if (!seen) chk(1'b0, "done_timeout", 0, 1);
    repeat (4) @(posedge clk);
    #1;
    chk(done_cnt[g] - d0 == 1, "done_pulses_once", done_cnt[g] - d0, 1);
    chk(busy[g] == 1'b0, "idle_after_done", int'(busy[g]), 0);
  endtask

  initial begin
    int n;
    rstn     = 1'b0;
    pipe_clr = 1'b1;
    cyc      = 0;
    for (int g = 0; g < 2; g++) begin
      start[g]    = 1'b0;
      spur[g]     = 1'b0;
      ovf_arm[g]  = 1'b0;
      vcnt_clr[g] = 1'b1;
      exp_ovf[g]  = 1'b0;
      done_cnt[g] = 0;
      rd_cnt[g]   = 0;
      wr_cnt[g]   = 0;
      peak[g]     = 0;
      last_wr[g]  = 0;
    end
    #3;
    for (int g = 0; g < 2; g++) chk(outs(g) == 0, "reset_outputs", outs(g), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rstn = 1'b1;
    pipe_clr = 1'b0;
    vcnt_clr[0] = 1'b0;
    vcnt_clr[1] = 1'b0;

    // Run 1: both instances; a second start mid-run on instance 0 must be ignored.
    push_run(0);
    push_run(1);
    do_start(0);
    do_start(1);
    repeat (3) @(posedge clk);
    #1 start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    wait_done(0);
    wait_done(1);
    chk(peak[0] == 4, "peak_inflight_max8", peak[0], 4);
    chk(peak[1] == 2, "peak_inflight_max2", peak[1], 2);

    // Run 2: overflow on the 7th result must be sticky at done.
    exp_ovf[0] = 1'b1;
    ovf_arm[0] = 1'b1;
    push_run(0);
    do_start(0);
    wait_done(0);
    ovf_arm[0] = 1'b0;

    // Run 3: the next start clears ovf_sticky.
    exp_ovf[0] = 1'b0;
    push_run(0);
    do_start(0);
    wait_done(0);

    // Spurious result while idle.
    @(posedge clk);
    #1 spur[0] = 1'b1;
    @(negedge clk);
    chk(mem_wr_en[0] == 1'b0, "spurious_no_write", int'(mem_wr_en[0]), 0);
    @(posedge clk);
    #1 spur[0] = 1'b0;
    chk(err[0] == 1'b1, "spurious_sets_err", int'(err[0]), 1);

    // Abort with reset on the third stage-1 read, two butterflies still in flight.
    push_run(0);
    do_start(0);
    n = 0;
    for (int i = 0; i < 200 && n < 3; i++) begin
      @(negedge clk);
      if (mem_rd_en[0] && stage[0] == 2'd1) n++;
    end
    chk(n == 3, "reached_stage1", n, 3);
    #1 rstn = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) chk(outs(g) == 0, "async_reset_outputs", outs(g), 0);
    #1 rstn = 1'b1;
    exp_rd[0].delete();
    exp_wr[0].delete();
    repeat (10) @(posedge clk);
    #1;
    chk(err[0] == 1'b1, "stale_result_sets_err", int'(err[0]), 1);
    chk(busy[0] == 1'b0, "idle_after_abort", int'(busy[0]), 0);
    push_run(0);
    do_start(0);
    wait_done(0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fix_bf_sched.md
FIX_BF_SCHED -- requirements
Module: fix_bf_sched

Interface
REQ-001 SHALL have parameter LOG2N, default 8, log2 of the FFT length (N = 2^LOG2N points, LOG2N stages, N/2 butterflies per stage).
REQ-002 SHALL have parameter MAX_OUT, default 8 (power of two), the maximum number of butterflies in flight.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, a one-cycle request to run a full FFT.
REQ-006 SHALL have port busy, output, 1, high from accepted start until done.
REQ-007 SHALL have port done, output, 1, a one-cycle pulse after the final writeback.
REQ-008 SHALL have port stage, output, LOG2N width rounded up (clog2), the stage currently issuing.
REQ-009 SHALL have ports mem_rd_en (output, 1), rd_addr_a and rd_addr_b (outputs, LOG2N each), the operand read request.
REQ-010 SHALL have port tw_addr, output, LOG2N-1, the twiddle ROM index issued with the read.
REQ-011 SHALL have port en, output, 1, operand-valid to the butterfly.
REQ-012 SHALL have port vld_out, input, 1, result-valid from the butterfly.
REQ-013 SHALL have port overflow, input, 1, the butterfly overflow flag, qualified by vld_out.
REQ-014 SHALL have ports mem_wr_en (output, 1), wr_addr_a and wr_addr_b (outputs, LOG2N each), the in-place writeback of y1/y2.
REQ-015 SHALL have port ovf_sticky, output, 1, set by any qualified overflow during the run.
REQ-016 SHALL have port err, output, 1, sticky; set by vld_out arriving while nothing is outstanding.

Function
REQ-017 SHALL use FSM states IDLE, ISSUE, DRAIN, DONE; transitions are IDLE->ISSUE on start, ISSUE->DRAIN after the last pair of a stage, DRAIN->ISSUE (stage+1) when outstanding=0 and stage<LOG2N-1, DRAIN->DONE when outstanding=0 and stage=LOG2N-1, and DONE->IDLE after one cycle.
REQ-018 SHALL compute addresses for stage s and pair k (0..N/2-1) as half=2^s, j=k mod half, a=(k>>s)*2^(s+1)+j, b=a+half, tw_addr=j<<(LOG2N-1-s); these are in-place radix-2 DIT addresses with input in bit-reversed order.
REQ-019 SHALL in ISSUE assert mem_rd_en with k advancing by one per cycle whenever outstanding<MAX_OUT; otherwise it stalls with k held.
REQ-020 SHALL assume a fixed memory read latency of 1 cycle: en is mem_rd_en delayed by one register.
REQ-021 SHALL push (a,b) into an internal address FIFO of depth MAX_OUT on each issue.
REQ-022 SHALL on vld_out pop the FIFO head and assert mem_wr_en with wr_addr_a/b in the same cycle (combinational from the head).
REQ-023 SHALL have the outstanding counter +1 on issue, -1 on vld_out, and unchanged on simultaneous issue and vld_out.
REQ-024 SHALL enforce a stage barrier: no read of stage s+1 until every stage-s writeback is done.
REQ-025 SHALL pulse done in the DONE state; busy SHALL be low in IDLE and DONE.
REQ-026 SHALL ignore start while busy; start in DONE SHALL also be ignored.
REQ-027 SHALL on vld_out with an empty FIFO set err, keep mem_wr_en low, and leave the counter unchanged.
REQ-028 SHALL clear ovf_sticky and err on an accepted start.

Reset
REQ-029 SHALL on rstn low immediately clear all outputs to 0, the FSM to IDLE, the FIFO pointers and counters to 0, and stage to 0.
REQ-030 SHALL treat reset mid-run as an abort: in-flight results arriving after reset release SHALL set err and SHALL NOT be written.

Structure
REQ-031 SHALL place FSM state encodings in shared package fix_fft_pkg.
REQ-032 SHALL place the address function from REQ-018 in shared package fix_fft_pkg.
REQ-033 SHALL implement the address FIFO as one sub-module fix_addr_fifo, parameterised by width and depth, with full/empty flags.

Verification
REQ-034 SHALL run with LOG2N=3, MAX_OUT=8 and a butterfly model of latency 3: start -> stage-0 reads (0,1),(2,3),(4,5),(6,7) with tw 0; stage-1 reads (0,2),(1,3),(4,6),(5,7) with tw 0,2,0,2; stage-2 reads (0,4),(1,5),(2,6),(3,7) with tw 0,1,2,3; writes match the reads in order; done pulses once after 12 writes.
REQ-035 SHALL run with MAX_OUT=2 and a model of latency 5: at most 2 issues between writebacks, with no FIFO overflow.
REQ-036 SHALL check the barrier: the first stage-1 mem_rd_en occurs at least one cycle after the 4th stage-0 mem_wr_en.
REQ-037 SHALL inject overflow=1 with the 7th vld_out: ovf_sticky=1 at done and cleared by the next start.
REQ-038 SHALL inject a spurious vld_out in IDLE: err=1, mem_wr_en=0.
REQ-039 SHALL assert rstn low during stage 1: all outputs are 0 in the same cycle, and a new start yields the complete sequence from REQ-034.
